// File: rtl/decode_queue.sv
// RV32I decode front-end: decodes each fetched instruction on entry and queues the control word for execute.
// Optional M-extension decode is enabled by defining DECODE_RV32M_EN.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   input  logic [PC_W-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [6:0]                 out_opcode,
   output logic [2:0]                 out_funct3,
   output logic [4:0]                 out_rd,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [31:0]                out_imm,
   output logic [3:0]                 out_aluop,
   output logic                       out_alu_src2_imm,
   output logic                       out_load_regfile,
   output logic                       out_mem_read,
   output logic                       out_mem_write,
   output logic [3:0]                 out_mem_byte_enable,
   output logic                       out_branch,
   output logic                       out_jump,
   output logic                       out_muldiv,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [31:0]     imm;
      logic [3:0]      aluop;
      logic            alu_src2_imm;
      logic            load_regfile;
      logic            mem_read;
      logic            mem_write;
      logic [3:0]      be;
      logic            branch;
      logic            jump;
      logic            muldiv;
      logic            illegal;
   } dec_t;

   dec_t            mem [DEPTH];
   dec_t            dec_p0;
   dec_t            head_p1;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            push;
   logic            pop;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            ill;
   logic            alt;

   assign opc   = in_instr[6:0];
   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   // Stage p0: combinational decode of the incoming instruction
   always_comb begin
      dec_p0        = '0;
      ill           = 1'b0;
      alt           = 1'b0;
      dec_p0.pc     = in_pc;
      dec_p0.opcode = opc;
      dec_p0.funct3 = f3;
      dec_p0.rd     = in_instr[11:7];
      dec_p0.rs1    = in_instr[19:15];
      dec_p0.rs2    = in_instr[24:20];
      dec_p0.be     = 4'b1111;
      case (opc)
         OP_LUI, OP_AUIPC: begin
            dec_p0.imm          = imm_u;
            dec_p0.load_regfile = 1'b1;
         end
         OP_JAL: begin
            dec_p0.imm          = imm_j;
            dec_p0.jump         = 1'b1;
            dec_p0.load_regfile = 1'b1;
         end
         OP_JALR: begin
            dec_p0.imm          = imm_i;
            dec_p0.jump         = 1'b1;
            dec_p0.load_regfile = 1'b1;
            ill                 = (f3 != 3'b000);
         end
         OP_BR: begin
            dec_p0.imm    = imm_b;
            dec_p0.branch = 1'b1;
            ill           = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_LOAD: begin
            dec_p0.imm          = imm_i;
            dec_p0.mem_read     = 1'b1;
            dec_p0.load_regfile = 1'b1;
            dec_p0.alu_src2_imm = 1'b1;
            ill                 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OP_STORE: begin
            dec_p0.imm          = imm_s;
            dec_p0.mem_write    = 1'b1;
            dec_p0.alu_src2_imm = 1'b1;
            ill                 = (f3 > 3'b010);
            if (f3 == 3'b000)
               dec_p0.be = 4'b0001;
            else if (f3 == 3'b001)
               dec_p0.be = 4'b0011;
         end
         OP_IMM: begin
            dec_p0.imm          = imm_i;
            dec_p0.alu_src2_imm = 1'b1;
            dec_p0.load_regfile = 1'b1;
            alt                 = (f3 == 3'b101) && in_instr[30];
            ill                 = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                                  ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
         end
         OP_REG: begin
            dec_p0.load_regfile = 1'b1;
            if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
               dec_p0.muldiv = 1'b1;
`else
               ill = 1'b1;
`endif
            end else begin
               alt = ((f3 == 3'b000) || (f3 == 3'b101)) && in_instr[30];
               ill = !((f7 == 7'b0000000) ||
                       ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
         end
         default: ill = 1'b1;
      endcase
      dec_p0.aluop = {alt, f3};
      // Illegal words travel down the queue but must not trigger any side effect
      if (ill) begin
         dec_p0.load_regfile = 1'b0;
         dec_p0.mem_read     = 1'b0;
         dec_p0.mem_write    = 1'b0;
         dec_p0.branch       = 1'b0;
         dec_p0.jump         = 1'b0;
         dec_p0.muldiv       = 1'b0;
         dec_p0.alu_src2_imm = 1'b0;
         dec_p0.aluop        = 4'b0000;
         dec_p0.imm          = 32'b0;
      end
      dec_p0.illegal = ill;
   end

   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Stage p1: FIFO control state
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= dec_p0;
   end

   // Stage p1 output: head entry, zeroed whenever the queue is empty
   assign head_p1 = out_valid ? mem[rd_ptr] : '0;

   assign out_pc              = head_p1.pc;
   assign out_opcode          = head_p1.opcode;
   assign out_funct3          = head_p1.funct3;
   assign out_rd              = head_p1.rd;
   assign out_rs1             = head_p1.rs1;
   assign out_rs2             = head_p1.rs2;
   assign out_imm             = head_p1.imm;
   assign out_aluop           = head_p1.aluop;
   assign out_alu_src2_imm    = head_p1.alu_src2_imm;
   assign out_load_regfile    = head_p1.load_regfile;
   assign out_mem_read        = head_p1.mem_read;
   assign out_mem_write       = head_p1.mem_write;
   assign out_mem_byte_enable = head_p1.be;
   assign out_branch          = head_p1.branch;
   assign out_jump            = head_p1.jump;
   assign out_muldiv          = head_p1.muldiv;
   assign out_illegal         = head_p1.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO ordering, full/wrap, flush and illegal handling.
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [3:0]  out_aluop, out_mem_byte_enable;
   logic        out_alu_src2_imm, out_load_regfile, out_mem_read, out_mem_write;
   logic        out_branch, out_jump, out_muldiv, out_illegal;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   decode_queue #(.DEPTH(4), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
      .out_aluop(out_aluop), .out_alu_src2_imm(out_alu_src2_imm),
      .out_load_regfile(out_load_regfile), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_mem_byte_enable(out_mem_byte_enable),
      .out_branch(out_branch), .out_jump(out_jump), .out_muldiv(out_muldiv),
      .out_illegal(out_illegal), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Advance one clock; inputs and samples both sit 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      step(); step();
      rst = 1'b0;
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      tests++; if (out_mem_byte_enable !== 4'b0000 || out_pc !== 32'h0) begin fails++;
         $display("FAIL reset_zero_data got be=%b pc=%h want 0000/0", out_mem_byte_enable, out_pc); end
   endtask

   task automatic test_addi();
      out_ready = 1'b0;
      push_one(32'h00500093, 32'h100);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %b want 1", out_valid); end
      tests++; if (out_imm !== 32'd5) begin fails++; $display("FAIL addi_imm got %h want 5", out_imm); end
      tests++; if (out_rd !== 5'd1) begin fails++; $display("FAIL addi_rd got %0d want 1", out_rd); end
      tests++; if (out_aluop !== 4'b0000) begin fails++; $display("FAIL addi_aluop got %b want 0000", out_aluop); end
      tests++; if (out_alu_src2_imm !== 1'b1 || out_load_regfile !== 1'b1) begin fails++;
         $display("FAIL addi_ctl got src2=%b lr=%b want 1/1", out_alu_src2_imm, out_load_regfile); end
      tests++; if (count !== 3'd1) begin fails++; $display("FAIL addi_count got %0d want 1", count); end
      tests++; if (out_pc !== 32'h100 || out_illegal !== 1'b0) begin fails++;
         $display("FAIL addi_pc got pc=%h ill=%b want 100/0", out_pc, out_illegal); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || count !== 3'd0) begin fails++;
         $display("FAIL addi_pop got valid=%b imm=%h count=%0d want 0/0/0", out_valid, out_imm, count); end
   endtask

   task automatic test_alt();
      push_one(32'h40208033, 32'h200);
      push_one(32'h4020D093, 32'h204);
      tests++; if (out_aluop !== 4'b1000 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin fails++;
         $display("FAIL sub_aluop got aluop=%b rs1=%0d rs2=%0d want 1000/1/2", out_aluop, out_rs1, out_rs2); end
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL alt_count got %0d want 2", count); end
      out_ready = 1'b1; step();
      tests++; if (out_aluop !== 4'b1101 || out_pc !== 32'h204 || out_alu_src2_imm !== 1'b1) begin fails++;
         $display("FAIL srai_aluop got aluop=%b pc=%h src2=%b want 1101/204/1", out_aluop, out_pc, out_alu_src2_imm); end
      step(); out_ready = 1'b0;
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL alt_drain got %0d want 0", count); end
   endtask

   task automatic test_formats();
      push_one(32'h008000EF, 32'h300);   // jal x1, 8
      push_one(32'h00208463, 32'h304);   // beq x1, x2, 8
      push_one(32'hFFC12283, 32'h308);   // lw x5, -4(x2)
      push_one(32'h12345037, 32'h30C);   // lui x0, 0x12345
      out_ready = 1'b1;
      tests++; if (out_jump !== 1'b1 || out_load_regfile !== 1'b1 || out_imm !== 32'd8 || out_rd !== 5'd1) begin fails++;
         $display("FAIL jal got jump=%b lr=%b imm=%h rd=%0d want 1/1/8/1", out_jump, out_load_regfile, out_imm, out_rd); end
      step();
      tests++; if (out_branch !== 1'b1 || out_load_regfile !== 1'b0 || out_imm !== 32'd8 || out_jump !== 1'b0) begin fails++;
         $display("FAIL beq got br=%b lr=%b imm=%h jump=%b want 1/0/8/0", out_branch, out_load_regfile, out_imm, out_jump); end
      step();
      tests++; if (out_mem_read !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_rd !== 5'd5 || out_mem_byte_enable !== 4'b1111) begin fails++;
         $display("FAIL lw got rd=%b imm=%h rdidx=%0d be=%b want 1/fffffffc/5/1111", out_mem_read, out_imm, out_rd, out_mem_byte_enable); end
      step();
      tests++; if (out_imm !== 32'h12345000 || out_load_regfile !== 1'b1 || out_pc !== 32'h30C) begin fails++;
         $display("FAIL lui got imm=%h lr=%b pc=%h want 12345000/1/30c", out_imm, out_load_regfile, out_pc); end
      step(); out_ready = 1'b0;
   endtask

   task automatic test_full_wrap();
      logic [31:0] st [4];
      logic [3:0]  be [4];
      st[0] = 32'h00000023; st[1] = 32'h00001023; st[2] = 32'h00002023; st[3] = 32'h00000023;
      be[0] = 4'b0001; be[1] = 4'b0011; be[2] = 4'b1111; be[3] = 4'b0001;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_one(st[i], 32'h400 + 32'(4*i));
      tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin fails++;
         $display("FAIL full got count=%0d in_ready=%b want 4/0", count, in_ready); end
      push_one(32'h00002023, 32'h500);
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_refuse got count=%0d want 4", count); end
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00001023; in_pc = 32'h600;
      for (int i = 0; i < 4; i++) begin
         tests++; if (out_mem_byte_enable !== be[i] || out_pc !== 32'h400 + 32'(4*i) || out_mem_write !== 1'b1) begin fails++;
            $display("FAIL wrap_order[%0d] got be=%b pc=%h want be=%b pc=%h", i, out_mem_byte_enable, out_pc, be[i], 32'h400 + 32'(4*i)); end
         step();
      end
      in_valid = 1'b0;
      tests++; if (count !== 3'd3 || out_pc !== 32'h600 || out_mem_byte_enable !== 4'b0011) begin fails++;
         $display("FAIL wrap_tail got count=%0d pc=%h be=%b want 3/600/0011", count, out_pc, out_mem_byte_enable); end
      step(); step(); step(); out_ready = 1'b0;
      tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++;
         $display("FAIL wrap_drain got count=%0d valid=%b want 0/0", count, out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_one(32'h00500093, 32'h700 + 32'(4*i));
      tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre got count=%0d want 3", count); end
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h7F0;
      step();
      flush = 1'b0; in_valid = 1'b0;
      tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++;
         $display("FAIL flush_clear got count=%0d valid=%b want 0/0", count, out_valid); end
      step();
      tests++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin fails++;
         $display("FAIL flush_discard got valid=%b pc=%h want 0/0", out_valid, out_pc); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b0;
      push_one(32'hFFFFFFFF, 32'h800);
      push_one(32'h00003003, 32'h804);
      tests++; if (out_illegal !== 1'b1 || out_load_regfile !== 1'b0 || out_mem_read !== 1'b0 || out_mem_write !== 1'b0 ||
                   out_branch !== 1'b0 || out_jump !== 1'b0 || out_muldiv !== 1'b0 || out_aluop !== 4'b0 || out_imm !== 32'h0) begin
         fails++;
         $display("FAIL ill_ones got ill=%b lr=%b mr=%b mw=%b br=%b j=%b md=%b aluop=%b imm=%h want 1/0/0/0/0/0/0/0000/0",
                  out_illegal, out_load_regfile, out_mem_read, out_mem_write, out_branch, out_jump, out_muldiv, out_aluop, out_imm);
      end
      out_ready = 1'b1; step();
      tests++; if (out_illegal !== 1'b1 || out_mem_read !== 1'b0 || out_load_regfile !== 1'b0 || out_imm !== 32'h0 || out_pc !== 32'h804) begin
         fails++;
         $display("FAIL ill_load got ill=%b mr=%b lr=%b imm=%h pc=%h want 1/0/0/0/804", out_illegal, out_mem_read, out_load_regfile, out_imm, out_pc);
      end
      step(); out_ready = 1'b0;
   endtask

   task automatic test_muldiv();
      out_ready = 1'b0;
      push_one(32'h022080B3, 32'h900);
`ifdef DECODE_RV32M_EN
      tests++; if (out_muldiv !== 1'b1 || out_illegal !== 1'b0 || out_load_regfile !== 1'b1 || out_aluop !== 4'b0000) begin fails++;
         $display("FAIL mul got md=%b ill=%b lr=%b aluop=%b want 1/0/1/0000", out_muldiv, out_illegal, out_load_regfile, out_aluop); end
`else
      tests++; if (out_illegal !== 1'b1 || out_muldiv !== 1'b0 || out_load_regfile !== 1'b0) begin fails++;
         $display("FAIL mul got ill=%b md=%b lr=%b want 1/0/0", out_illegal, out_muldiv, out_load_regfile); end
`endif
      out_ready = 1'b1; step(); out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_alt();
      test_formats();
      test_full_wrap();
      test_flush();
      test_illegal();
      test_muldiv();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
